reg_file_wr_decode: RTL and testbench
=====================================

Name: reg_file_wr_decode

Overview:
- Register file for the single-cycle MIPS datapath.
- Receives the 5-bit destination-register address produced by the destination-select stage, decodes it one-hot (the demultiplexing direction of that selection), and writes the selected register on the clock edge.
- Provides two combinational read ports (rs, rt) feeding the ALU operand path.
- Register $0 is hardwired to zero; same-cycle write-to-read bypass is optional.

Parameters:
DATA_W, 32, width of each register and of all data ports
ADDR_W, 5, register address width; register count = 2**ADDR_W
BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data; 0 = returns the stored (old) value

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe (RegWrite from control)
wr_addr  input  ADDR_W  destination register from destination-select stage
wr_data  input  DATA_W  write-back value
rd_addr_a  input  ADDR_W  read port A address (rs)
rd_addr_b  input  ADDR_W  read port B address (rt)
rd_data_a  output  DATA_W  read port A data
rd_data_b  output  DATA_W  read port B data
wr_onehot  output  2**ADDR_W  registered one-hot of the last committed write (debug/trace); bit 0 never set

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - all registers cleared to 0
  - wr_onehot cleared to 0
  - rd_data_a and rd_data_b therefore read 0 for every address while reset is held.
- Decode: combinational one-hot of wr_addr, gated by wr_en. Bit 0 is forced to 0.
- Write:
  - On a rising clk edge with rst_n high, wr_en = 1 and wr_addr != 0, reg[wr_addr] <= wr_data.
  - Latency is 1 cycle: the value is visible from stored state after that edge.
- $0 rule:
  - A write to address 0 is discarded: no state change, and wr_onehot is set to all-zero on that edge.
  - Reads of address 0 always return 0, independent of BYPASS.
- wr_onehot: on each clk edge it loads the gated decode value, i.e. exactly one bit set after a valid write, all-zero otherwise.
- Reads: fully combinational, with zero-cycle latency from address change.
- Bypass (BYPASS = 1):
  - If wr_en = 1, wr_addr != 0 and rd_addr_x == wr_addr, then rd_data_x = wr_data in the same cycle.
  - Both ports bypass independently, including when rd_addr_a == rd_addr_b == wr_addr.
- BYPASS = 0: reads return the pre-edge stored value; the new value appears after the edge.
- wr_en = 0: no state change regardless of wr_addr/wr_data; no bypass.
- Reset asserted mid-operation:
  - Clears all state immediately and overrides any coincident write.
  - The first write accepted is on the first rising edge after rst_n returns high.
- X on wr_addr while wr_en = 0 must not corrupt state.
- Width rules:
  - No arithmetic is performed.
  - wr_addr is used at full ADDR_W width; there are no out-of-range addresses since the register count is 2**ADDR_W.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5, pulse rst_n low for 3 ns with no clock edge -> rd_data_a at rd_addr_a=5 reads 0x00000000 immediately; wr_onehot = 0.
- Basic write/read: wr_en=1, wr_addr=31, wr_data=0x12345678, one edge, then wr_en=0, rd_addr_b=31 -> rd_data_b = 0x12345678; wr_onehot = 0x80000000.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, one edge -> rd_data_a(0) = 0; wr_onehot = 0; no other register changed (spot-check r1 = 0).
- Bypass with BYPASS=1: r7=0x11111111 stored; drive wr_en=1, wr_addr=7, wr_data=0x22222222, rd_addr_a=rd_addr_b=7 before the edge -> both read 0x22222222 pre-edge. With BYPASS=0 the same stimulus -> both read 0x11111111 pre-edge and 0x22222222 post-edge.
- Write disabled: r3=0xA5A5A5A5; wr_en=0, wr_addr=3, wr_data=0 for 4 edges -> r3 stays 0xA5A5A5A5; wr_onehot = 0.
- Reset mid-write: wr_en=1, wr_addr=9, wr_data=0xCAFEF00D with rst_n low across the edge -> r9 = 0. After rst_n high, the next edge -> r9 = 0xCAFEF00D and wr_onehot = 0x00000200.

Source files
------------

// File: rtl/reg_file_wr_decode_if.sv
// Register-file bus: one write port, two read ports, write trace.
// master = datapath side, slave = register file side.
interface reg_file_wr_decode_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic [ADDR_W-1:0]    rd_addr_a;
  logic [ADDR_W-1:0]    rd_addr_b;
  logic [DATA_W-1:0]    rd_data_a;
  logic [DATA_W-1:0]    rd_data_b;
  logic [2**ADDR_W-1:0] wr_onehot;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_onehot
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_onehot
  );
endinterface

// File: rtl/reg_file_wr_decode.sv
// MIPS register file with one-hot write decode, $0 hardwired to zero.
// Two combinational read ports with optional same-cycle write bypass.
module reg_file_wr_decode #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_file_wr_decode_if.slave bus
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_onehot;
  logic [NREG-1:0]   w_dec;
  logic              w_wr_live;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // wr_en gates before indexing so an X address cannot reach state
  always_comb begin
    w_dec = '0;
    if (bus.wr_en)
      w_dec[bus.wr_addr] = 1'b1;
    w_dec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_onehot <= '0;
    end else begin
      r_onehot <= w_dec;
      for (int i = 1; i < NREG; i++)
        if (w_dec[i])
          r_regs[i] <= bus.wr_data;
    end
  end

  // bypass only a write that will actually commit
  assign w_wr_live = rst_n && bus.wr_en
                  && (bus.wr_addr != '0);

  always_comb begin
    w_rd_a = r_regs[bus.rd_addr_a];
    if (BYPASS != 0 && w_wr_live
        && bus.rd_addr_a == bus.wr_addr)
      w_rd_a = bus.wr_data;
    if (bus.rd_addr_a == '0)
      w_rd_a = '0;
  end

  always_comb begin
    w_rd_b = r_regs[bus.rd_addr_b];
    if (BYPASS != 0 && w_wr_live
        && bus.rd_addr_b == bus.wr_addr)
      w_rd_b = bus.wr_data;
    if (bus.rd_addr_b == '0)
      w_rd_b = '0;
  end

  assign bus.rd_data_a = w_rd_a;
  assign bus.rd_data_b = w_rd_b;
  assign bus.wr_onehot = r_onehot;

endmodule

// File: tb/tb_reg_file_wr_decode.sv
// Directed bench for reg_file_wr_decode.
// Runs a bypass and a non-bypass instance side by side.
module tb_reg_file_wr_decode;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  reg_file_wr_decode_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
  reg_file_wr_decode_if #(.DATA_W(32), .ADDR_W(5)) ifn ();

  reg_file_wr_decode #(
    .DATA_W(32), .ADDR_W(5), .BYPASS(1)
  ) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  reg_file_wr_decode #(
    .DATA_W(32), .ADDR_W(5), .BYPASS(0)
  ) u_nob (
    .clk(clk), .rst_n(rst_n), .bus(ifn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(
    input logic        en,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  ra,
    input logic [4:0]  rb
  );
    ifb.wr_en = en; ifn.wr_en = en;
    ifb.wr_addr = wa; ifn.wr_addr = wa;
    ifb.wr_data = wd; ifn.wr_data = wd;
    ifb.rd_addr_a = ra; ifn.rd_addr_a = ra;
    ifb.rd_addr_b = rb; ifn.rd_addr_b = rb;
  endtask

  task automatic wr1(
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    @(negedge clk);
    drv(1'b1, wa, wd, 5'd0, 5'd0);
    @(posedge clk); #1;
    drv(1'b0, wa, wd, 5'd0, 5'd0);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst_n = 1'b0;
    drv(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #12;
    chk("rst_rd_a", ifb.rd_data_a, 32'h0);
    chk("rst_rd_b", ifn.rd_data_b, 32'h0);
    chk("rst_oh", ifb.wr_onehot, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset with no clock edge
    wr1(5'd5, 32'hDEADBEEF);
    drv(1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
    #1;
    chk("r5_wr", ifb.rd_data_a, 32'hDEADBEEF);
    chk("r5_oh", ifb.wr_onehot, 32'h00000020);
    rst_n = 1'b0;
    #1;
    chk("async_rd_b", ifb.rd_data_a, 32'h0);
    chk("async_rd_n", ifn.rd_data_a, 32'h0);
    chk("async_oh", ifb.wr_onehot, 32'h0);
    #2;
    rst_n = 1'b1;

    // basic write to r31
    wr1(5'd31, 32'h12345678);
    drv(1'b0, 5'd31, 32'h0, 5'd5, 5'd31);
    #1;
    chk("r31_b", ifb.rd_data_b, 32'h12345678);
    chk("r31_n", ifn.rd_data_b, 32'h12345678);
    chk("r31_oh", ifb.wr_onehot, 32'h80000000);
    chk("r5_clr", ifn.rd_data_a, 32'h0);

    // write to $0 is dropped, even under bypass
    @(negedge clk);
    drv(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd1);
    #1;
    chk("z_byp", ifb.rd_data_a, 32'h0);
    @(posedge clk); #1;
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    #1;
    chk("z_rd", ifb.rd_data_a, 32'h0);
    chk("z_r1", ifb.rd_data_b, 32'h0);
    chk("z_oh", ifb.wr_onehot, 32'h0);
    chk("z_oh_n", ifn.wr_onehot, 32'h0);

    // bypass vs stored value on r7
    wr1(5'd7, 32'h11111111);
    @(negedge clk);
    drv(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    #1;
    chk("byp_a", ifb.rd_data_a, 32'h22222222);
    chk("byp_b", ifb.rd_data_b, 32'h22222222);
    chk("nob_a_pre", ifn.rd_data_a, 32'h11111111);
    chk("nob_b_pre", ifn.rd_data_b, 32'h11111111);
    @(posedge clk); #1;
    drv(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    #1;
    chk("nob_a_post", ifn.rd_data_a, 32'h22222222);
    chk("nob_b_post", ifn.rd_data_b, 32'h22222222);
    chk("byp_post", ifb.rd_data_a, 32'h22222222);
    chk("r7_oh", ifn.wr_onehot, 32'h00000080);

    // write disabled, including an unknown address
    wr1(5'd3, 32'hA5A5A5A5);
    @(negedge clk);
    drv(1'b0, 5'd3, 32'h0, 5'd3, 5'd7);
    #1;
    chk("dis_nobyp", ifb.rd_data_a, 32'hA5A5A5A5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    drv(1'b0, 5'bxxxxx, 32'h0, 5'd3, 5'd7);
    repeat (2) @(posedge clk);
    #1;
    drv(1'b0, 5'd3, 32'h0, 5'd3, 5'd7);
    #1;
    chk("dis_r3", ifb.rd_data_a, 32'hA5A5A5A5);
    chk("dis_r3_n", ifn.rd_data_a, 32'hA5A5A5A5);
    chk("dis_r7", ifb.rd_data_b, 32'h22222222);
    chk("dis_oh", ifb.wr_onehot, 32'h0);

    // reset held across a write edge
    @(negedge clk);
    drv(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rw_r9_b", ifb.rd_data_a, 32'h0);
    chk("rw_r9_n", ifn.rd_data_a, 32'h0);
    chk("rw_r3", ifb.rd_data_b, 32'h0);
    chk("rw_oh", ifb.wr_onehot, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw_pre_n", ifn.rd_data_a, 32'h0);
    @(posedge clk); #1;
    drv(1'b0, 5'd9, 32'h0, 5'd9, 5'd3);
    #1;
    chk("rw_r9", ifn.rd_data_a, 32'hCAFEF00D);
    chk("rw_r9_byp", ifb.rd_data_a, 32'hCAFEF00D);
    chk("rw_oh_post", ifn.wr_onehot, 32'h00000200);
    chk("rw_r3_post", ifn.rd_data_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
